// File: rtl/alu.sv
// Registered 4-bit arithmetic/logic/shift unit: one operation accepted per cycle,
// result and carry/shift-out flag registered on the following rising edge.
module alu (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] X,
  input  logic [3:0] Y,
  input  logic [2:0] S,
  input  logic [1:0] shamt,
  input  logic       d,
  output logic [3:0] outp,
  output logic       cout
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHF = 3'b110;
  localparam logic [2:0] OP_ROT = 3'b111;

  // Logical shift returning {shift_out, result}; the bit that falls just past
  // the 4-bit window is the last one shifted out, and is 0 when shamt is 0.
  function automatic logic [4:0] shift_op(input logic [3:0] a, input logic [1:0] n,
                                          input logic right);
    logic [7:0] ext;
    if (right) begin
      ext = {a, 4'b0000} >> n;
      return {ext[3], ext[7:4]};
    end else begin
      ext = {4'b0000, a} << n;
      return {ext[4], ext[3:0]};
    end
  endfunction

  function automatic logic [3:0] rotate_op(input logic [3:0] a, input logic [1:0] n,
                                           input logic right);
    logic [7:0] dbl;
    if (right) begin
      dbl = {a, a} >> n;
      return dbl[3:0];
    end else begin
      dbl = {a, a} << n;
      return dbl[7:4];
    end
  endfunction

  logic [3:0] r_p0;
  logic       c_p0;

  always_comb begin
    r_p0 = 4'b0000;
    c_p0 = 1'b0;
    case (S)
      OP_ADD:  {c_p0, r_p0} = {1'b0, X} + {1'b0, Y};
      OP_SUB:  {c_p0, r_p0} = {1'b0, X} + {1'b0, ~Y} + 5'd1;
      OP_AND:  r_p0 = X & Y;
      OP_OR:   r_p0 = X | Y;
      OP_XOR:  r_p0 = X ^ Y;
      OP_NOT:  r_p0 = ~X;
      OP_SHF:  {c_p0, r_p0} = shift_op(X, shamt, d);
      OP_ROT:  r_p0 = rotate_op(X, shamt, d);
      default: begin
        r_p0 = 4'b0000;
        c_p0 = 1'b0;
      end
    endcase
  end

  // Stage p0 -> p1: result register; reset overrides the operation in flight.
  logic [3:0] outp_p1;
  logic       cout_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      outp_p1 <= 4'b0000;
      cout_p1 <= 1'b0;
    end else begin
      outp_p1 <= r_p0;
      cout_p1 <= c_p0;
    end
  end

  assign outp = outp_p1;
  assign cout = cout_p1;

endmodule

// File: tb/tb_alu.sv
// Directed and exhaustive self-checking bench for the registered 4-bit ALU.
module tb_alu;

  logic       clk;
  logic       rst;
  logic [3:0] X;
  logic [3:0] Y;
  logic [2:0] S;
  logic [1:0] shamt;
  logic       d;
  logic [3:0] outp;
  logic       cout;

  int n_cmp;
  int n_bad;

  alu dut (
    .clk   (clk),
    .rst   (rst),
    .X     (X),
    .Y     (Y),
    .S     (S),
    .shamt (shamt),
    .d     (d),
    .outp  (outp),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply inputs away from the edge, then wait until just after the capturing edge.
  task automatic drive(input logic r, input logic [3:0] a, input logic [3:0] b,
                       input logic [2:0] s, input logic [1:0] n, input logic dir);
    @(negedge clk);
    rst = r; X = a; Y = b; S = s; shamt = n; d = dir;
    @(posedge clk);
    #1;
  endtask

  // Reference model written bit-by-bit, returns {c, r}.
  function automatic logic [4:0] model(input logic [3:0] a, input logic [3:0] b,
                                       input logic [2:0] s, input logic [1:0] n,
                                       input logic dir);
    int sum;
    logic [3:0] r;
    logic c;
    r = 4'b0000;
    c = 1'b0;
    case (s)
      3'd0: begin
        sum = int'(a) + int'(b);
        r = sum[3:0];
        c = (sum > 15);
      end
      3'd1: begin
        sum = int'(a) - int'(b);
        r = sum[3:0];
        c = (a >= b);
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = ~a;
      3'd6: begin
        r = a;
        for (int i = 0; i < int'(n); i++) begin
          if (dir) begin c = r[0]; r = {1'b0, r[3:1]}; end
          else     begin c = r[3]; r = {r[2:0], 1'b0}; end
        end
      end
      default: begin
        r = a;
        for (int i = 0; i < int'(n); i++) begin
          if (dir) r = {r[0], r[3:1]};
          else     r = {r[2:0], r[3]};
        end
      end
    endcase
    return {c, r};
  endfunction

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 4'b1111, 4'b1111, 3'b000, 2'b00, 1'b0);
      n_cmp++;
      if (outp !== 4'b0000 || cout !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_hold[%0d] got %b/%b expected 0000/0", i, outp, cout);
      end
    end
    drive(1'b0, 4'b1111, 4'b1111, 3'b000, 2'b00, 1'b0);
    n_cmp++;
    if (outp !== 4'b1110 || cout !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_release got %b/%b expected 1110/1", outp, cout);
    end
  endtask

  task automatic test_addsub();
    logic [3:0] xa [3] = '{4'b1111, 4'b0011, 4'b0101};
    logic [3:0] ya [3] = '{4'b0001, 4'b0101, 4'b0011};
    logic [2:0] sa [3] = '{3'b000, 3'b001, 3'b001};
    logic [3:0] ea [3] = '{4'b0000, 4'b1110, 4'b0010};
    logic       ca [3] = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, xa[i], ya[i], sa[i], 2'b00, 1'b0);
      n_cmp++;
      if (outp !== ea[i] || cout !== ca[i]) begin
        n_bad++;
        $display("FAIL addsub[%0d] got %b/%b expected %b/%b", i, outp, cout, ea[i], ca[i]);
      end
    end
  endtask

  task automatic test_logic();
    logic [2:0] sa [4] = '{3'b010, 3'b011, 3'b100, 3'b101};
    logic [3:0] ea [4] = '{4'b1000, 4'b1110, 4'b0110, 4'b0011};
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 4'b1100, 4'b1010, sa[i], 2'b11, 1'b1);
      n_cmp++;
      if (outp !== ea[i] || cout !== 1'b0) begin
        n_bad++;
        $display("FAIL logic[%0d] got %b/%b expected %b/0", i, outp, cout, ea[i]);
      end
    end
  endtask

  task automatic test_shift();
    logic [1:0] na [3] = '{2'b01, 2'b10, 2'b00};
    logic       da [3] = '{1'b0, 1'b1, 1'b0};
    logic [3:0] ea [3] = '{4'b0110, 4'b0010, 4'b1011};
    logic       ca [3] = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 4'b1011, 4'b0101, 3'b110, na[i], da[i]);
      n_cmp++;
      if (outp !== ea[i] || cout !== ca[i]) begin
        n_bad++;
        $display("FAIL shift[%0d] got %b/%b expected %b/%b", i, outp, cout, ea[i], ca[i]);
      end
    end
  endtask

  task automatic test_rotate();
    logic [3:0] xa [3] = '{4'b1001, 4'b1001, 4'b0110};
    logic [1:0] na [3] = '{2'b01, 2'b01, 2'b11};
    logic       da [3] = '{1'b0, 1'b1, 1'b0};
    logic [3:0] ea [3] = '{4'b0011, 4'b1100, 4'b0011};
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, xa[i], 4'b1111, 3'b111, na[i], da[i]);
      n_cmp++;
      if (outp !== ea[i] || cout !== 1'b0) begin
        n_bad++;
        $display("FAIL rotate[%0d] got %b/%b expected %b/0", i, outp, cout, ea[i]);
      end
    end
  endtask

  // Outputs must not follow inputs between edges.
  task automatic test_hold();
    drive(1'b0, 4'b0111, 4'b0001, 3'b000, 2'b00, 1'b0);
    @(negedge clk);
    X = 4'b0000; Y = 4'b0000; S = 3'b101;
    #2;
    n_cmp++;
    if (outp !== 4'b1000 || cout !== 1'b0) begin
      n_bad++;
      $display("FAIL hold got %b/%b expected 1000/0", outp, cout);
    end
  endtask

  task automatic test_sweep();
    logic [13:0] v;
    logic [4:0]  exp;
    for (int i = 0; i < 16384; i++) begin
      v = 14'(i);
      if (i == 8000) begin
        drive(1'b1, v[13:10], v[9:6], v[5:3], v[2:1], v[0]);
        exp = 5'b00000;
      end else begin
        drive(1'b0, v[13:10], v[9:6], v[5:3], v[2:1], v[0]);
        exp = model(v[13:10], v[9:6], v[5:3], v[2:1], v[0]);
      end
      n_cmp++;
      if ({cout, outp} !== exp) begin
        n_bad++;
        $display("FAIL sweep[%0d] got %b/%b expected %b/%b", i, outp, cout, exp[3:0], exp[4]);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1; X = '0; Y = '0; S = '0; shamt = '0; d = 1'b0;
    test_reset();
    test_addsub();
    test_logic();
    test_shift();
    test_rotate();
    test_hold();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
